// File: rtl/xor_descrambler_pkg.sv
// Shared constants and FSM encoding for the XOR descrambler slice.
package xor_descrambler_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] POLY_DEFAULT     = 8'hB8;
  localparam logic [DATA_W-1:0] ZERO_SUB_DEFAULT = 8'hFF;
  localparam logic [DATA_W-1:0] LFSR_RESET       = 8'h01;

  typedef enum logic {
    UNSEEDED = 1'b0,
    RUN      = 1'b1
  } desc_state_t;

endpackage

// File: rtl/xor_gate8.sv
// Bytewise XOR gate block.
module xor_gate8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_lfsr_step.sv
// One Galois LFSR step. The zero guard keeps the register out of the
// lock-up state even if a non-primitive POLY is supplied.
module xor_lfsr_step
  import xor_descrambler_pkg::*;
#(
  parameter logic [DATA_W-1:0] ZERO_SUB = ZERO_SUB_DEFAULT
) (
  input  logic [DATA_W-1:0] state,
  input  logic [DATA_W-1:0] poly,
  output logic [DATA_W-1:0] next
);

  logic [DATA_W-1:0] shifted_s;

  // Shift right, folding the feedback mask in when the LSB is set
  always_comb begin
    shifted_s = {1'b0, state[DATA_W-1:1]};
    if (state[0]) begin
      shifted_s = {1'b0, state[DATA_W-1:1]} ^ poly;
    end else begin
      shifted_s = {1'b0, state[DATA_W-1:1]};
    end
    if (shifted_s == {DATA_W{1'b0}}) begin
      next = ZERO_SUB;
    end else begin
      next = shifted_s;
    end
  end

endmodule

// File: rtl/xor_descrambler.sv
// Additive descrambler: XORs each accepted byte with a Galois LFSR keystream,
// with a one-deep registered output stage and seed-controlled start.
module xor_descrambler
  import xor_descrambler_pkg::*;
#(
  parameter logic [7:0] POLY     = POLY_DEFAULT,
  parameter logic [7:0] ZERO_SUB = ZERO_SUB_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_load,
  input  logic [7:0] seed,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       seeded,
  output logic [7:0] byte_cnt
);

  desc_state_t       state_r, state_nxt_s;
  logic [7:0]        lfsr_r;
  logic [7:0]        lfsr_nxt_s;
  logic [7:0]        xor_s;
  logic              out_valid_r;
  logic [7:0]        out_data_r;
  logic [7:0]        byte_cnt_r;
  logic              in_ready_s;
  logic              accept_s;

  xor_lfsr_step #(
    .ZERO_SUB (ZERO_SUB)
  ) u_step (
    .state (lfsr_r),
    .poly  (POLY),
    .next  (lfsr_nxt_s)
  );

  xor_gate8 u_xor (
    .a (in_data),
    .b (lfsr_r),
    .y (xor_s)
  );

  // Seeding has priority over data, so a reseed cycle never consumes a byte
  assign in_ready_s = (state_r == RUN) && (!out_valid_r || out_ready) && !seed_load;
  assign accept_s   = in_valid && in_ready_s;

  // FSM next-state: any seed_load lands in RUN; only rst leaves it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      UNSEEDED: begin
        if (seed_load) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = UNSEEDED;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = UNSEEDED;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= UNSEEDED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // LFSR and byte counter: seed_load reloads, accept advances
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r     <= LFSR_RESET;
      byte_cnt_r <= 8'h00;
    end else if (seed_load) begin
      lfsr_r     <= (seed == 8'h00) ? ZERO_SUB : seed;
      byte_cnt_r <= 8'h00;
    end else if (accept_s) begin
      lfsr_r     <= lfsr_nxt_s;
      byte_cnt_r <= byte_cnt_r + 8'd1;
    end
  end

  // Output stage: a pending byte survives reseeds until it is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= xor_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign byte_cnt  = byte_cnt_r;
  assign seeded    = (state_r == RUN);

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed plus randomized bench for xor_descrambler with a keystream reference model.
module tb_xor_descrambler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       seeded;
  logic [7:0] byte_cnt;

  int passed = 0;
  int total  = 0;

  // reference model state
  bit         m_seeded = 1'b0;
  int         m_key    = 1;
  bit         m_ov     = 1'b0;
  int         m_od     = 0;
  int         m_cnt    = 0;
  logic [7:0] got [4];

  xor_descrambler dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .seeded    (seeded),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  // keystream advance: halve, folding in the polynomial when the low bit was odd
  function automatic int next_key(input int k);
    if (k % 2 == 1) return (k / 2) ^ 32'hB8;
    return k / 2;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // one clock: check in_ready for the driven inputs, predict, clock, check registers
  task automatic step();
    bit exp_ir, acc;
    #1;
    exp_ir = m_seeded && (!m_ov || out_ready) && !seed_load && !rst;
    if (!rst) chk("in_ready", {7'b0, in_ready}, {7'b0, exp_ir});
    acc = exp_ir && in_valid;
    if (rst) begin
      m_seeded = 1'b0; m_key = 1; m_ov = 1'b0; m_od = 0; m_cnt = 0;
    end else begin
      if (acc) begin
        m_ov = 1'b1;
        m_od = int'(in_data) ^ m_key;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (seed_load) begin
        m_seeded = 1'b1;
        m_key    = (seed == 8'h00) ? 255 : int'(seed);
        m_cnt    = 0;
      end else if (acc) begin
        m_key = next_key(m_key);
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", {7'b0, out_valid}, {7'b0, m_ov});
    chk("out_data",  out_data, 8'(m_od));
    chk("byte_cnt",  byte_cnt, 8'(m_cnt));
    chk("seeded",    {7'b0, seeded}, {7'b0, m_seeded});
  endtask

  task automatic do_seed(input logic [7:0] s);
    seed_load = 1'b1; seed = s; in_valid = 1'b0;
    step();
    seed_load = 1'b0;
  endtask

  initial begin
    // reset, then data offered with no seed must be refused
    rst = 1'b1; in_valid = 1'b1; seed_load = 1'b1; seed = 8'h5A;
    step();
    rst = 1'b0; seed_load = 1'b0; in_data = 8'h33; out_ready = 1'b1;
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_in_ready", {7'b0, in_ready}, 8'h00);
    repeat (3) step();
    chk("unseeded_out_valid", {7'b0, out_valid}, 8'h00);

    // seed 01, four zero bytes -> raw keystream
    do_seed(8'h01);
    in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      got[i] = out_data;
    end
    chk("ks0", got[0], 8'h01);
    chk("ks1", got[1], 8'hB8);
    chk("ks2", got[2], 8'h5C);
    chk("ks3", got[3], 8'h2E);
    chk("cnt4", byte_cnt, 8'h04);
    in_valid = 1'b0;
    step();

    // seed 01, byte FF -> FE
    do_seed(8'h01);
    in_valid = 1'b1; in_data = 8'hFF;
    step();
    chk("ff_xor", out_data, 8'hFE);
    in_valid = 1'b0;
    step();

    // all-zero seed substitutes FF
    do_seed(8'h00);
    in_valid = 1'b1; in_data = 8'h00;
    step();
    chk("zero_sub", out_data, 8'hFF);

    // backpressure with a pending byte, then release
    out_ready = 1'b0; in_data = 8'h12;
    step();
    got[0] = out_data;
    step();
    step();
    chk("held_data", out_data, got[0]);
    chk("bp_in_ready", {7'b0, in_ready}, 8'h00);
    out_ready = 1'b1;
    step();
    chk("release_cnt", byte_cnt, 8'h02);

    // reseed with a pending byte and in_valid in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    step();
    got[1] = out_data;
    seed_load = 1'b1; seed = 8'hC3;
    step();
    seed_load = 1'b0;
    chk("reseed_keep", out_data, got[1]);
    chk("reseed_cnt", byte_cnt, 8'h00);
    out_ready = 1'b1;

    // 256 accepts -> counter wraps to zero
    for (int i = 0; i < 256; i++) begin
      in_data = 8'($urandom);
      step();
    end
    chk("wrap_cnt", byte_cnt, 8'h00);

    // random traffic with occasional reseeds
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 31) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step();
    end
    seed_load = 1'b0;

    // reset mid-stream overrides everything
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b1; seed_load = 1'b1; seed = 8'h42;
    step();
    rst = 1'b0; seed_load = 1'b0;
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_cnt", byte_cnt, 8'h00);
    chk("rst_seeded", {7'b0, seeded}, 8'h00);
    #1;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
